// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
// Module      : vga_capture
// Description : 1-bpp parallel video capture. Measures horizontal/vertical
//               timing, locks after two matching frames, then packs active
//               pixels DW per word and writes them to a VRAM-style port.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_capture #(
    parameter int DW     = 8,
    parameter int AW     = 16,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic          clk25m,
    input  logic          rst,
    input  logic          red,
    input  logic          grn,
    input  logic          blu,
    input  logic          hs,
    input  logic          vs,
    input  logic          de,
    output logic [AW-1:0] vram_waddr,
    output logic [DW-1:0] vram_wdata,
    output logic          vram_we,
    output logic [11:0]   h_total,
    output logic [11:0]   h_active,
    output logic [11:0]   v_total,
    output logic [11:0]   v_active,
    output logic          locked,
    output logic          frame
);

    localparam int          BW   = $clog2(DW);
    localparam logic [11:0] CMAX = 12'hFFF;
    localparam logic [BW-1:0] LAST = BW'(DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CMAX) ? v : v + 12'd1;
    endfunction

    logic pix_q, hs_q, hs_p, vs_q, vs_p, de_q, de_p;
    logic [11:0] hcnt, decnt, lcnt, acnt;
    logic [11:0] htot_c, hact_c;
    logic [11:0] ref_htot, ref_hact, ref_vtot, ref_vact;
    state_t      state, state_n;
    logic        ref_load;
    logic        cap;
    logic [BW-1:0] bitpos;
    logic [DW-1:0] asm_q;

    logic        hs_edge, vs_edge, hs_lost, line_act;
    logic [11:0] w_htot, w_hact, w_vtot, w_vact;
    logic        w_good;
    logic [DW-1:0] w_asm;

    assign hs_edge  = (hs_q == HS_POL) && (hs_p != HS_POL);
    assign vs_edge  = (vs_q == VS_POL) && (vs_p != VS_POL);
    // A fresh HS edge rescues the saturated counter in the same cycle.
    assign hs_lost  = (hcnt == CMAX) && !hs_edge;
    assign line_act = hs_edge && (decnt != 12'd0);

    // Candidates as they stand including any HS edge in this very cycle,
    // so a coincident HS is counted in the frame that is ending.
    assign w_htot = hs_edge  ? hcnt          : htot_c;
    assign w_hact = line_act ? decnt         : hact_c;
    assign w_vtot = hs_edge  ? sat_inc(lcnt) : lcnt;
    assign w_vact = line_act ? sat_inc(acnt) : acnt;

    assign w_good = (w_htot == ref_htot) && (w_hact == ref_hact) &&
                    (w_vtot == ref_vtot) && (w_vact == ref_vact) &&
                    (w_htot != 12'd0) && (w_hact != 12'd0) &&
                    (w_vtot != 12'd0) && (w_vact != 12'd0);

    // Start a fresh word at bit 0 so a flushed partial word has zero upper bits.
    assign w_asm = ((bitpos == '0) ? '0 : asm_q) | (DW'(pix_q) << bitpos);

    assign locked = (state == ST_LOCKED);

    // Input registers plus one extra stage for edge detection.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            pix_q <= 1'b0;
            hs_q  <= 1'b0;
            hs_p  <= 1'b0;
            vs_q  <= 1'b0;
            vs_p  <= 1'b0;
            de_q  <= 1'b0;
            de_p  <= 1'b0;
        end else begin
            pix_q <= red | grn | blu;
            hs_q  <= hs;
            hs_p  <= hs_q;
            vs_q  <= vs;
            vs_p  <= vs_q;
            de_q  <= de;
            de_p  <= de_q;
        end
    end

    // Horizontal line length and DE width counters.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            hcnt   <= 12'd0;
            decnt  <= 12'd0;
            htot_c <= 12'd0;
            hact_c <= 12'd0;
        end else if (hs_edge) begin
            hcnt   <= 12'd1;
            decnt  <= {11'd0, de_q};
            htot_c <= hcnt;
            if (decnt != 12'd0) begin
                hact_c <= decnt;
            end
        end else begin
            hcnt <= sat_inc(hcnt);
            if (de_q) begin
                decnt <= sat_inc(decnt);
            end
        end
    end

    // Vertical line and active-line counters, restarted at each VS edge.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            lcnt <= 12'd0;
            acnt <= 12'd0;
        end else if (vs_edge) begin
            lcnt <= 12'd0;
            acnt <= 12'd0;
        end else begin
            if (hs_edge) begin
                lcnt <= sat_inc(lcnt);
            end
            if (line_act) begin
                acnt <= sat_inc(acnt);
            end
        end
    end

    // Measurement outputs latched at each VS edge, with a frame pulse.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            h_total  <= 12'd0;
            h_active <= 12'd0;
            v_total  <= 12'd0;
            v_active <= 12'd0;
            frame    <= 1'b0;
        end else begin
            frame <= vs_edge;
            if (vs_edge) begin
                h_total  <= w_htot;
                h_active <= w_hact;
                v_total  <= w_vtot;
                v_active <= w_vact;
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Lock next-state logic; decisions are taken only on VS edges.
    always_comb begin
        state_n  = state;
        ref_load = 1'b0;
        if (hs_lost) begin
            state_n = ST_IDLE;
        end else if (vs_edge) begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_MEASURE;
                end
                ST_MEASURE: begin
                    state_n  = ST_CHECK;
                    ref_load = 1'b1;
                end
                ST_CHECK: begin
                    if (w_good) begin
                        state_n = ST_LOCKED;
                    end else begin
                        ref_load = 1'b1;
                    end
                end
                default: begin
                    if (!w_good) begin
                        state_n  = ST_CHECK;
                        ref_load = 1'b1;
                    end
                end
            endcase
        end
    end

    // Reference timing used to judge the next frame.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            ref_htot <= 12'd0;
            ref_hact <= 12'd0;
            ref_vtot <= 12'd0;
            ref_vact <= 12'd0;
        end else if (ref_load) begin
            ref_htot <= w_htot;
            ref_hact <= w_hact;
            ref_vtot <= w_vtot;
            ref_vact <= w_vact;
        end
    end

    // Capture enable follows the lock decision at frame boundaries.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            cap <= 1'b0;
        end else if (vs_edge || hs_lost) begin
            cap <= (state_n == ST_LOCKED);
        end
    end

    // Pixel packing, word writes, partial-word flush and address counter.
    always_ff @(posedge clk25m) begin
        if (rst) begin
            bitpos     <= '0;
            asm_q      <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            vram_waddr <= '0;
        end else begin
            vram_we <= 1'b0;
            if (cap && de_q) begin
                asm_q <= w_asm;
                if (bitpos == LAST) begin
                    vram_we    <= 1'b1;
                    vram_wdata <= w_asm;
                    bitpos     <= '0;
                end else begin
                    bitpos <= bitpos + BW'(1);
                end
            end else if (!de_q && de_p && (bitpos != '0)) begin
                vram_we    <= 1'b1;
                vram_wdata <= asm_q;
                bitpos     <= '0;
            end
            if (vs_edge) begin
                vram_waddr <= '0;
            end else if (vram_we) begin
                vram_waddr <= vram_waddr + AW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_capture
// Description : Scoreboard bench for vga_capture using a reduced video
//               timing (24 clocks x 10 lines) so many frames fit in a run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_capture;

    localparam int VT     = 10;
    localparam int VA     = 6;
    localparam int VSTART = 2;
    localparam int VSW    = 2;
    localparam int HSW    = 2;
    localparam int HSTART = 4;

    logic        clk25m = 1'b0;
    logic        rst;
    logic        red, grn, blu, hs, vs, de;
    logic [15:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [11:0] h_total, h_active, v_total, v_active;
    logic        locked, frame;

    int n_checks = 0;
    int n_fail   = 0;
    int frames_seen = 0;
    int frames_sent = 0;
    int exp_addr[$];
    int exp_data[$];

    vga_capture #(.DW(8), .AW(16), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
        .clk25m     (clk25m),
        .rst        (rst),
        .red        (red),
        .grn        (grn),
        .blu        (blu),
        .hs         (hs),
        .vs         (vs),
        .de         (de),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .h_total    (h_total),
        .h_active   (h_active),
        .v_total    (v_total),
        .v_active   (v_active),
        .locked     (locked),
        .frame      (frame)
    );

    always #20 clk25m = ~clk25m;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe is matched against the expected queue.
    initial begin
        forever begin
            @(posedge clk25m);
            #1;
            if (frame) frames_seen++;
            if (vram_we) begin
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none at %0t",
                             vram_waddr, vram_wdata, $time);
                end else begin
                    check("wr_addr", int'(vram_waddr), exp_addr.pop_front());
                    check("wr_data", int'(vram_wdata), exp_data.pop_front());
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk25m);
            hs = 1'b1; vs = 1'b1; de = 1'b0;
            red = 1'b0; grn = 1'b0; blu = 1'b0;
        end
    endtask

    // One frame. cap: expect this frame captured; exp_lock: locked state
    // just after the opening VS edge; chk_h*: measurements of previous frame
    // (0 = skip); rst_line >= 0 pulses rst during that active line.
    task automatic drive_frame(input int htot, input int hact, input int mode,
                               input bit cap, input bit exp_lock,
                               input int exp_full, input int exp_part,
                               input int chk_htot, input int chk_hact,
                               input int rst_line);
        int  addr = 0;
        bit  act, d, p, rst_pend;
        rst_pend = 1'b0;
        frames_sent++;
        for (int l = 0; l < VT; l++) begin
            act = (l >= VSTART) && (l < VSTART + VA);
            if (cap && act && (rst_line < 0 || l < rst_line)) begin
                for (int w = 0; w < hact / 8; w++) begin
                    exp_addr.push_back(addr); exp_data.push_back(exp_full); addr++;
                end
                if (hact % 8 != 0) begin
                    exp_addr.push_back(addr); exp_data.push_back(exp_part); addr++;
                end
            end
            for (int x = 0; x < htot; x++) begin
                @(negedge clk25m);
                if (rst_pend) begin
                    check("rst_we_lock_frame", {vram_we, locked, frame}, 0);
                    check("rst_waddr", int'(vram_waddr), 0);
                    check("rst_wdata", int'(vram_wdata), 0);
                    check("rst_htot_hact", {h_total, h_active}, 0);
                    check("rst_vtot_vact", {v_total, v_active}, 0);
                    rst_pend = 1'b0;
                end
                d = act && (x >= HSTART) && (x < HSTART + hact);
                p = d && (mode == 1 || ((x - HSTART) % 2 == 0));
                hs  = (x < HSW) ? 1'b0 : 1'b1;
                vs  = (l < VSW) ? 1'b0 : 1'b1;
                de  = d;
                red = p && (x % 3 == 0);
                grn = p && (x % 3 == 1);
                blu = p && (x % 3 == 2);
                rst = (l == rst_line) && (x == HSTART + 3);
                if (rst) rst_pend = 1'b1;
                if (l == 0 && x == 6) begin
                    check("locked", int'(locked), int'(exp_lock));
                    if (chk_htot != 0) begin
                        check("h_total", int'(h_total), chk_htot);
                        check("h_active", int'(h_active), chk_hact);
                        check("v_total", int'(v_total), VT);
                        check("v_active", int'(v_active), VA);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        hs = 1'b1; vs = 1'b1; de = 1'b0;
        red = 1'b0; grn = 1'b0; blu = 1'b0;
        repeat (3) @(negedge clk25m);
        check("reset_we_lock_frame", {vram_we, locked, frame}, 0);
        check("reset_htot", int'(h_total), 0);
        check("reset_vtot", int'(v_total), 0);
        check("reset_waddr", int'(vram_waddr), 0);
        rst = 1'b0;
        idle_cycles(5);

        // Lock on alternating-pixel source, 16 active pixels per line.
        drive_frame(24, 16, 0, 0, 0, 0, 0, 0, 0, -1);
        drive_frame(24, 16, 0, 0, 0, 0, 0, 0, 0, -1);
        drive_frame(24, 16, 0, 1, 1, 8'h55, 0, 24, 16, -1);
        drive_frame(24, 16, 0, 1, 1, 8'h55, 0, 24, 16, -1);

        // DE width 13 with all pixels set: full word plus 5-bit flush.
        drive_frame(24, 13, 1, 1, 1, 8'hFF, 8'h1F, 24, 16, -1);
        drive_frame(24, 13, 1, 0, 0, 0, 0, 24, 13, -1);
        drive_frame(24, 13, 1, 1, 1, 8'hFF, 8'h1F, 24, 13, -1);

        // One frame with a longer line, then relock.
        drive_frame(25, 13, 1, 1, 1, 8'hFF, 8'h1F, 24, 13, -1);
        drive_frame(24, 13, 1, 0, 0, 0, 0, 25, 13, -1);
        drive_frame(24, 13, 1, 0, 0, 0, 0, 24, 13, -1);
        drive_frame(24, 13, 1, 1, 1, 8'hFF, 8'h1F, 24, 13, -1);

        // HS loss drops lock; three VS edges regain it.
        idle_cycles(4200);
        check("hs_loss_locked", int'(locked), 0);
        drive_frame(24, 13, 1, 0, 0, 0, 0, 0, 0, -1);
        drive_frame(24, 13, 1, 0, 0, 0, 0, 0, 0, -1);
        drive_frame(24, 13, 1, 1, 1, 8'hFF, 8'h1F, 24, 13, -1);

        // Reset pulse inside active line 4; only lines 2 and 3 get written.
        drive_frame(24, 13, 1, 1, 1, 8'hFF, 8'h1F, 24, 13, 4);
        drive_frame(24, 13, 1, 0, 0, 0, 0, 0, 0, -1);
        drive_frame(24, 13, 1, 0, 0, 0, 0, 0, 0, -1);
        drive_frame(24, 13, 1, 1, 1, 8'hFF, 8'h1F, 24, 13, -1);

        idle_cycles(50);
        check("writes_outstanding", exp_addr.size(), 0);
        check("frame_pulses", frames_seen, frames_sent);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
